// File: rtl/panel_pwr_seq_if.sv
// Panel power sequencer signal bundle.
//   iPWR_REQ   : panel-on request, asynchronous level
//   iTX_LOCKED : LVDS transmitter MMCM lock, asynchronous level
//   oVDD_EN    : panel VDD enable
//   oLVDS_EN   : LVDS data/clock enable (0 holds the serializer in reset)
//   oBL_EN     : backlight enable
//   oREADY     : high only while the panel is fully on
//   oFAULT     : sticky lock-lost-while-sequenced-up flag
//   oSTATE     : current sequencer state encoding
// The master drives the requests; the slave (the sequencer) drives the enables.
interface panel_pwr_seq_if;
  logic       iPWR_REQ;
  logic       iTX_LOCKED;
  logic       oVDD_EN;
  logic       oLVDS_EN;
  logic       oBL_EN;
  logic       oREADY;
  logic       oFAULT;
  logic [2:0] oSTATE;

  modport master (
    output iPWR_REQ, iTX_LOCKED,
    input  oVDD_EN, oLVDS_EN, oBL_EN, oREADY, oFAULT, oSTATE
  );

  modport slave (
    input  iPWR_REQ, iTX_LOCKED,
    output oVDD_EN, oLVDS_EN, oBL_EN, oREADY, oFAULT, oSTATE
  );
endinterface

// File: rtl/panel_pwr_seq.sv
// Panel power sequencer: brings panel VDD, LVDS and backlight up in order with
// millisecond spacing, and tears them down in reverse order, with a minimum
// VDD-off cooldown before the panel may be powered again.
//   iOSC   : the only clock
//   iRESET : asynchronous active-low reset; drops every enable at once
//   bus    : request/lock inputs and enable/status outputs (slave side)
// Timed states dwell exactly Tx * TICK_DIV cycles. A T*_MS of 0 acts as 1.
module panel_pwr_seq #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned T2_MS    = 20,
  parameter int unsigned T3_MS    = 200,
  parameter int unsigned T4_MS    = 200,
  parameter int unsigned T5_MS    = 20,
  parameter int unsigned T7_MS    = 500
) (
  input logic            iOSC,
  input logic            iRESET,
  panel_pwr_seq_if.slave bus
);

  localparam logic [15:0] PrescMax = 16'(TICK_DIV - 1);
  localparam logic [9:0]  T2Lim    = (T2_MS == 0) ? 10'd1 : 10'(T2_MS);
  localparam logic [9:0]  T3Lim    = (T3_MS == 0) ? 10'd1 : 10'(T3_MS);
  localparam logic [9:0]  T4Lim    = (T4_MS == 0) ? 10'd1 : 10'(T4_MS);
  localparam logic [9:0]  T5Lim    = (T5_MS == 0) ? 10'd1 : 10'(T5_MS);
  localparam logic [9:0]  T7Lim    = (T7_MS == 0) ? 10'd1 : 10'(T7_MS);

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StVddUp    = 3'd1,
    StLvdsUp   = 3'd2,
    StOn       = 3'd3,
    StBlDown   = 3'd4,
    StLvdsDown = 3'd5,
    StCooldown = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic        req_meta, req_sync;
  logic        lock_meta, lock_sync;
  logic [15:0] presc_q;
  logic [9:0]  ms_q;
  logic [9:0]  limit;
  logic        timed;
  logic        tick;
  logic        done;
  logic        up_abort;

  assign tick     = (presc_q == PrescMax);
  assign up_abort = !req_sync || !lock_sync;

  always_comb begin
    limit = T2Lim;
    timed = 1'b1;
    case (state_q)
      StVddUp:    limit = T2Lim;
      StLvdsUp:   limit = T3Lim;
      StBlDown:   limit = T4Lim;
      StLvdsDown: limit = T5Lim;
      StCooldown: limit = T7Lim;
      default:    timed = 1'b0;
    endcase
    // Fires on the last prescaler cycle of the last ms, so the state edge lands
    // exactly limit * TICK_DIV cycles after entry.
    done = timed && tick && (ms_q == limit - 10'd1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StOff:      if (req_sync && lock_sync) state_d = StVddUp;
      StVddUp:    if (up_abort) state_d = StLvdsDown;
                  else if (done) state_d = StLvdsUp;
      StLvdsUp:   if (up_abort) state_d = StLvdsDown;
                  else if (done) state_d = StOn;
      StOn:       if (up_abort) state_d = StBlDown;
      StBlDown:   if (done) state_d = StLvdsDown;
      StLvdsDown: if (done) state_d = StCooldown;
      StCooldown: if (done) state_d = StOff;
      // Illegal encoding: the safe place is COOLDOWN, which keeps VDD off.
      default:    state_d = StCooldown;
    endcase
  end

  always_ff @(posedge iOSC or negedge iRESET) begin
    if (!iRESET) begin
      req_meta     <= 1'b0;
      req_sync     <= 1'b0;
      lock_meta    <= 1'b0;
      lock_sync    <= 1'b0;
      state_q      <= StOff;
      presc_q      <= '0;
      ms_q         <= '0;
      bus.oVDD_EN  <= 1'b0;
      bus.oLVDS_EN <= 1'b0;
      bus.oBL_EN   <= 1'b0;
      bus.oREADY   <= 1'b0;
      bus.oFAULT   <= 1'b0;
      bus.oSTATE   <= 3'd0;
    end else begin
      req_meta  <= bus.iPWR_REQ;
      req_sync  <= req_meta;
      lock_meta <= bus.iTX_LOCKED;
      lock_sync <= lock_meta;
      state_q   <= state_d;

      if (state_d != state_q) begin
        presc_q <= '0;
        ms_q    <= '0;
      end else if (timed) begin
        if (tick) begin
          presc_q <= '0;
          ms_q    <= ms_q + 10'd1;
        end else begin
          presc_q <= presc_q + 16'd1;
        end
      end

      // Outputs decode the next state so they move on the same edge as the state.
      bus.oVDD_EN  <= (state_d == StVddUp) || (state_d == StLvdsUp) || (state_d == StOn) ||
                      (state_d == StBlDown) || (state_d == StLvdsDown);
      bus.oLVDS_EN <= (state_d == StLvdsUp) || (state_d == StOn) || (state_d == StBlDown);
      bus.oBL_EN   <= (state_d == StOn);
      bus.oREADY   <= (state_d == StOn);
      bus.oSTATE   <= state_d;

      if (state_q == StOff && state_d == StVddUp) begin
        bus.oFAULT <= 1'b0;
      end else if (!lock_sync &&
                   (state_q == StVddUp || state_q == StLvdsUp || state_q == StOn)) begin
        bus.oFAULT <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_panel_pwr_seq.sv
module tb_panel_pwr_seq;

  logic osc = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic lvds_seen;

  always #5 osc = ~osc;

  panel_pwr_seq_if bus ();

  panel_pwr_seq #(
    .TICK_DIV (4),
    .T2_MS    (2),
    .T3_MS    (3),
    .T4_MS    (3),
    .T5_MS    (2),
    .T7_MS    (5)
  ) dut (
    .iOSC   (osc),
    .iRESET (rst),
    .bus    (bus)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic [2:0] st, input logic vdd,
                           input logic lvds, input logic bl);
    chk3({tag, ".state"}, bus.oSTATE, st);
    chk1({tag, ".vdd"}, bus.oVDD_EN, vdd);
    chk1({tag, ".lvds"}, bus.oLVDS_EN, lvds);
    chk1({tag, ".bl"}, bus.oBL_EN, bl);
    chk1({tag, ".ready"}, bus.oREADY, (st == 3'd3));
  endtask

  // Advance n clock cycles, sampling on the falling edge and checking the
  // enable ordering invariants on every cycle.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge osc);
      chk1("inv.bl_lvds", bus.oBL_EN && !bus.oLVDS_EN, 1'b0);
      chk1("inv.lvds_vdd", bus.oLVDS_EN && !bus.oVDD_EN, 1'b0);
      if (bus.oLVDS_EN) lvds_seen = 1'b1;
    end
  endtask

  initial begin
    lvds_seen      = 1'b0;
    rst            = 1'b0;
    bus.iPWR_REQ   = 1'b1;
    bus.iTX_LOCKED = 1'b1;

    // Reset state, with request already pending.
    cyc(3);
    expect_st("rst", 3'd0, 1'b0, 1'b0, 1'b0);
    chk1("rst.fault", bus.oFAULT, 1'b0);

    // Power-up: first transition only on the 3rd edge after release.
    rst = 1'b1;
    cyc(2);
    expect_st("pu.e2", 3'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    expect_st("pu.e3", 3'd1, 1'b1, 1'b0, 1'b0);
    cyc(7);
    expect_st("pu.t2m1", 3'd1, 1'b1, 1'b0, 1'b0);
    cyc(1);
    expect_st("pu.t2", 3'd2, 1'b1, 1'b1, 1'b0);
    cyc(11);
    expect_st("pu.t3m1", 3'd2, 1'b1, 1'b1, 1'b0);
    cyc(1);
    expect_st("pu.on", 3'd3, 1'b1, 1'b1, 1'b1);
    chk1("pu.fault", bus.oFAULT, 1'b0);

    // Power-down from ON.
    bus.iPWR_REQ = 1'b0;
    cyc(2);
    expect_st("pd.e2", 3'd3, 1'b1, 1'b1, 1'b1);
    cyc(1);
    expect_st("pd.bl", 3'd4, 1'b1, 1'b1, 1'b0);
    cyc(11);
    expect_st("pd.t4m1", 3'd4, 1'b1, 1'b1, 1'b0);
    cyc(1);
    expect_st("pd.lvds", 3'd5, 1'b1, 1'b0, 1'b0);
    cyc(7);
    expect_st("pd.t5m1", 3'd5, 1'b1, 1'b0, 1'b0);
    cyc(1);
    expect_st("pd.vdd", 3'd6, 1'b0, 1'b0, 1'b0);
    cyc(19);
    expect_st("pd.t7m1", 3'd6, 1'b0, 1'b0, 1'b0);
    cyc(1);
    expect_st("pd.off", 3'd0, 1'b0, 1'b0, 1'b0);
    chk1("pd.fault", bus.oFAULT, 1'b0);

    // Abort in VDD_UP: request drops partway through T2.
    lvds_seen    = 1'b0;
    bus.iPWR_REQ = 1'b1;
    cyc(3);
    expect_st("ab.vdd", 3'd1, 1'b1, 1'b0, 1'b0);
    cyc(3);
    bus.iPWR_REQ = 1'b0;
    cyc(2);
    expect_st("ab.e2", 3'd1, 1'b1, 1'b0, 1'b0);
    cyc(1);
    expect_st("ab.down", 3'd5, 1'b1, 1'b0, 1'b0);
    cyc(7);
    expect_st("ab.t5m1", 3'd5, 1'b1, 1'b0, 1'b0);
    cyc(1);
    expect_st("ab.cool", 3'd6, 1'b0, 1'b0, 1'b0);
    chk1("ab.lvds_never", lvds_seen, 1'b0);
    chk1("ab.fault", bus.oFAULT, 1'b0);
    cyc(20);
    expect_st("ab.off", 3'd0, 1'b0, 1'b0, 1'b0);

    // Lock loss in ON.
    bus.iPWR_REQ = 1'b1;
    cyc(3);
    expect_st("ll.vdd", 3'd1, 1'b1, 1'b0, 1'b0);
    cyc(8);
    cyc(12);
    expect_st("ll.on", 3'd3, 1'b1, 1'b1, 1'b1);
    bus.iTX_LOCKED = 1'b0;
    cyc(2);
    chk1("ll.fault_e2", bus.oFAULT, 1'b0);
    cyc(1);
    expect_st("ll.bl", 3'd4, 1'b1, 1'b1, 1'b0);
    chk1("ll.fault_set", bus.oFAULT, 1'b1);
    cyc(12);
    expect_st("ll.lvds", 3'd5, 1'b1, 1'b0, 1'b0);
    cyc(8);
    expect_st("ll.cool", 3'd6, 1'b0, 1'b0, 1'b0);

    // Re-request during COOLDOWN: request is held, lock comes back.
    bus.iTX_LOCKED = 1'b1;
    cyc(19);
    expect_st("rr.t7m1", 3'd6, 1'b0, 1'b0, 1'b0);
    chk1("rr.fault_hold", bus.oFAULT, 1'b1);
    cyc(1);
    expect_st("rr.off", 3'd0, 1'b0, 1'b0, 1'b0);
    chk1("rr.fault_off", bus.oFAULT, 1'b1);
    cyc(1);
    expect_st("rr.vdd", 3'd1, 1'b1, 1'b0, 1'b0);
    chk1("rr.fault_clr", bus.oFAULT, 1'b0);

    // Reset pulse in LVDS_UP drops everything without waiting for a clock.
    cyc(8);
    expect_st("rp.lvds", 3'd2, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    expect_st("rp.async", 3'd0, 1'b0, 1'b0, 1'b0);
    chk1("rp.fault", bus.oFAULT, 1'b0);
    cyc(1);
    rst = 1'b1;
    cyc(2);
    expect_st("rp.e2", 3'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    expect_st("rp.noT7", 3'd1, 1'b1, 1'b0, 1'b0);

    // Request and lock fall together in ON: lock-loss path with fault.
    cyc(8);
    cyc(12);
    expect_st("dual.on", 3'd3, 1'b1, 1'b1, 1'b1);
    bus.iPWR_REQ   = 1'b0;
    bus.iTX_LOCKED = 1'b0;
    cyc(3);
    expect_st("dual.bl", 3'd4, 1'b1, 1'b1, 1'b0);
    chk1("dual.fault", bus.oFAULT, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/panel_pwr_seq.md
PANEL_PWR_SEQ -- requirements
Module: panel_pwr_seq

Interface
REQ-001 Parameter TICK_DIV, default 50000, sets iOSC cycles per 1 ms tick; legal range 2..65535.
REQ-002 Parameter T2_MS, default 20, sets the ms delay from VDD on to LVDS on.
REQ-003 Parameter T3_MS, default 200, sets the ms delay from LVDS on to backlight on.
REQ-004 Parameter T4_MS, default 200, sets the ms delay from backlight off to LVDS off.
REQ-005 Parameter T5_MS, default 20, sets the ms delay from LVDS off to VDD off.
REQ-006 Parameter T7_MS, default 500, sets the minimum ms VDD-off time before re-power; all T*_MS values are 10-bit (1..1023), and 0 SHALL behave as 1.
REQ-007 Port iOSC, input, 1 bit: the only clock.
REQ-008 Port iRESET, input, 1 bit: reset, asynchronous and active-low.
REQ-009 Port iPWR_REQ, input, 1 bit, asynchronous level: 1 = panel on requested.
REQ-010 Port iTX_LOCKED, input, 1 bit, asynchronous level: LVDS transmitter MMCM locked.
REQ-011 Port oVDD_EN, output, 1 bit: panel VDD enable.
REQ-012 Port oLVDS_EN, output, 1 bit: enables LVDS data/clock (when 0, the serializer is held in reset).
REQ-013 Port oBL_EN, output, 1 bit: backlight enable.
REQ-014 Port oREADY, output, 1 bit: 1 only in state ON.
REQ-015 Port oFAULT, output, 1 bit: sticky flag for lock lost while sequenced up.
REQ-016 Port oSTATE, output, 3 bits: current state encoding.

Function
REQ-017 iPWR_REQ and iTX_LOCKED SHALL each pass a 2-flop synchronizer; "req" and "lock" below denote the synchronized values.
REQ-018 States and encodings: OFF=0, VDD_UP=1, LVDS_UP=2, ON=3, BL_DOWN=4, LVDS_DOWN=5, COOLDOWN=6; encoding 7 SHALL recover to COOLDOWN.
REQ-019 A ms prescaler and a 10-bit ms counter SHALL clear on every state change; each timed state exits on the cycle its counter reaches Tx, i.e. dwell equals exactly Tx*TICK_DIV cycles.
REQ-020 OFF -> VDD_UP when req=1 and lock=1.
REQ-021 VDD_UP -> LVDS_UP after T2; if req=0 or lock=0, go to LVDS_DOWN instead.
REQ-022 LVDS_UP -> ON after T3; if req=0 or lock=0, go to LVDS_DOWN instead.
REQ-023 ON -> BL_DOWN when req=0 or lock=0.
REQ-024 BL_DOWN -> LVDS_DOWN after T4; this state is not abortable.
REQ-025 LVDS_DOWN -> COOLDOWN after T5.
REQ-026 COOLDOWN -> OFF after T7; req is ignored until OFF is reached.
REQ-027 All outputs SHALL be registered and decoded from the next state, so they change on the same edge as the state.
REQ-028 Output values per state:
- oVDD_EN=1 in VDD_UP, LVDS_UP, ON, BL_DOWN, LVDS_DOWN.
- oLVDS_EN=1 in LVDS_UP, ON, BL_DOWN.
- oBL_EN=1 in ON only.
REQ-029 oFAULT SHALL set when lock=0 is seen in VDD_UP, LVDS_UP or ON, and SHALL clear on the OFF->VDD_UP transition.
REQ-030 Invariants: oBL_EN=1 implies oLVDS_EN=1, and oLVDS_EN=1 implies oVDD_EN=1, in every cycle.
REQ-031 When req falls and lock falls in the same cycle, the lock-loss path SHALL be taken and oFAULT set.

Reset
REQ-032 With iRESET=0, state SHALL be OFF, all outputs 0, and counters and synchronizers cleared, asynchronously.
REQ-033 After reset release, the first transition SHALL be possible no earlier than the 3rd edge (synchronizer latency).
REQ-034 Reset asserted mid-sequence SHALL drop all enables immediately with no sequencing; T7 is not enforced after reset.

Verification (TICK_DIV=4, T2=2, T3=3, T4=3, T5=2, T7=5)
REQ-035 Power-up: lock=1, req rises -> oVDD_EN at edge 3; oLVDS_EN 8 cycles later; oBL_EN and oREADY 12 cycles after that; oSTATE=3.
REQ-036 Power-down from ON: req falls -> oBL_EN=0 at edge 3; oLVDS_EN=0 12 cycles later; oVDD_EN=0 8 cycles later; OFF 20 cycles after that.
REQ-037 Abort in VDD_UP: req falls at cycle 4 of VDD_UP -> state LVDS_DOWN; oLVDS_EN never rises; oVDD_EN=0 8 cycles later.
REQ-038 Lock loss in ON -> oFAULT=1 with the normal power-down timing; oFAULT stays 1 until the next VDD_UP entry.
REQ-039 Re-request during COOLDOWN -> OFF is reached only after the full 20 cycles, then VDD_UP follows on the next edge.
REQ-040 iRESET pulse in LVDS_UP -> all outputs 0 asynchronously; the invariants of REQ-030 are checked every cycle across all scenarios.
